// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the single-cycle MIPS instruction memory.
// It receives a byte stream over a valid/ready handshake and first reads a
// 32-bit big-endian word count N. It then assembles N big-endian 32-bit words
// and writes them to word addresses 0..N-1. The core is held in reset until the
// image is completely loaded.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When defined, a trailing
// XOR checksum byte must match before the loader reports DONE.
module imem_loader #(
    parameter int ADDR_W = 13
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [31:0]       o_wdata,
    output logic              o_core_rst_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W:0]   o_word_cnt
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;
`else
    // S_FLUSH holds off DONE for one cycle so that the last write pulse
    // never overlaps the core being released from reset.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;
`endif

    localparam logic [32:0]     CAPACITY = 33'd1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t      state;
    state_t      state_next;
    logic [1:0]  phase;
    logic [31:0] len_reg;
    logic [31:0] len_full;
    logic        accept;
    logic        start_load;
    logic        oversize;
    logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign accept     = i_byte_valid & o_byte_ready;
    assign start_load = i_start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
    assign len_full   = {len_reg[23:0], i_byte};
    assign oversize   = {1'b0, len_full} > CAPACITY;
    assign last_word  = (o_word_cnt + CNT_ONE) == len_reg[ADDR_W:0];

    // State register, asynchronously forced back to IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the status outputs, which depend on state alone.
    always_comb begin
        state_next   = state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        o_core_rst_n = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (accept && (phase == 2'd3)) begin
                    if (oversize) begin
                        state_next = S_ERR;
                    end else if (len_full == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = S_CSUM;
`else
                        state_next = S_DONE;
`endif
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && (phase == 2'd3) && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = S_CSUM;
`else
                    state_next = S_FLUSH;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_next = (i_byte == csum) ? S_DONE : S_ERR;
                end
            end
`else
            S_FLUSH: begin
                state_next = S_DONE;
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase

        case (state)
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_LEN, S_DATA, S_CSUM: o_busy = 1'b1;
`else
            S_LEN, S_DATA:         o_busy = 1'b1;
`endif
            S_DONE: begin
                o_done       = 1'b1;
                o_core_rst_n = 1'b1;
            end
            S_ERR:   o_err = 1'b1;
            default: o_busy = 1'b0;
        endcase
    end

    assign o_byte_ready = o_busy;

    // Byte datapath: length capture, word assembly, write pulse and address counting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase      <= 2'd0;
            len_reg    <= 32'd0;
            o_we       <= 1'b0;
            o_waddr    <= '0;
            o_wdata    <= 32'd0;
            o_word_cnt <= '0;
        end else begin
            o_we <= accept && (state == S_DATA) && (phase == 2'd3);
            if (o_we) begin
                o_waddr    <= o_waddr + ADDR_ONE;
                o_word_cnt <= o_word_cnt + CNT_ONE;
            end
            if (start_load) begin
                phase      <= 2'd0;
                len_reg    <= 32'd0;
                o_waddr    <= '0;
                o_word_cnt <= '0;
            end else if (accept) begin
                phase <= phase + 2'd1;
                if (state == S_LEN) begin
                    len_reg <= len_full;
                end
                if (state == S_DATA) begin
                    o_wdata <= {o_wdata[23:0], i_byte};
                end
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over every accepted length and data byte.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            csum <= 8'd0;
        end else if (start_load) begin
            csum <= 8'd0;
        end else if (accept && ((state == S_LEN) || (state == S_DATA))) begin
            csum <= csum ^ i_byte;
        end
    end
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader in front of the instruction memory of the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes them to consecutive instruction-memory word addresses starting at 0. It holds the core in reset until the image is fully and correctly loaded.

## Interface
Parameters:
- ADDR_W, 13, instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  load request pulse. Honoured only in IDLE, DONE or ERR.
- i_byte  in  8  stream byte.
- i_byte_valid  in  1  i_byte is valid.
- o_byte_ready  out  1  loader accepts a byte this cycle.
- o_we  out  1  instruction-memory write enable. Single-cycle pulse per word.
- o_waddr  out  ADDR_W  word address for the write.
- o_wdata  out  32  word to write.
- o_core_rst_n  out  1  active-low reset to the core. High only in DONE.
- o_busy  out  1  high in LEN, DATA or CSUM.
- o_done  out  1  high in DONE.
- o_err  out  1  high in ERR.
- o_word_cnt  out  ADDR_W+1  words written in the current load.

## Operation
- A byte transfers on a cycle where i_byte_valid & o_byte_ready are both high. o_byte_ready = o_busy, combinational from state.
- States:
  - IDLE: on i_start go to LEN.
  - LEN: accept 4 bytes into a 32-bit length N, MSB first. After the 4th byte:
    - N > 2^ADDR_W: go to ERR.
    - N = 0: go to CSUM, or DONE when checksum is compiled out.
    - Otherwise: go to DATA.
  - DATA: accept 4 bytes per word, MSB first into o_wdata[31:24], then [23:16], [15:8], [7:0]. After the 4th byte of a word, o_we pulses with the current o_waddr. o_waddr and o_word_cnt then increment. After word N, go to CSUM, or DONE when checksum is compiled out.
  - CSUM: accept 1 byte. Equal to the running checksum: go to DONE. Otherwise: go to ERR.
  - DONE / ERR: wait. i_start restarts the load in LEN.
- Entering LEN clears the following:
  - o_waddr, o_word_cnt and the byte phase.
  - The length register and the checksum.
  - o_core_rst_n drops to 0 on that same edge.
- The running checksum is the XOR of all accepted length and data bytes.
- i_start is ignored while o_busy is high.
- Memory contents are never cleared. Words beyond N keep old values.

## Timing
- Reset values: state IDLE, o_we 0, o_waddr 0, o_wdata 0, o_word_cnt 0, o_core_rst_n 0. o_busy, o_done and o_err are all 0.
- i_start high at edge t: o_busy and o_byte_ready are 1 after edge t.
- 4th byte of a word accepted at edge t: o_we = 1 for exactly the cycle after t, with o_waddr and o_wdata stable. Address increments at edge t+1.
- Back-to-back words are legal at the maximum rate of one byte per cycle.
- The final transition to DONE takes effect on the edge after the last o_we pulse, or on the edge the CSUM byte is accepted, whichever comes later. o_core_rst_n never rises in the same cycle as an o_we pulse.
- Stalls: i_byte_valid low freezes all state. No timeout.
- Async i_rst mid-load:
  - All outputs take reset values immediately; o_we drops without waiting for the clock.
  - Partially loaded memory is left as is.
  - The core stays in reset.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: the CSUM state and trailing checksum byte are used as described above.
- IMEM_LOADER_CHECKSUM_EN undefined:
  - No CSUM state and no checksum logic.
  - A load ends in DONE right after word N, or straight from LEN when N = 0.
  - ERR is reachable only via oversize N.

## Test plan
- Load N=2, words 0x20080005 and 0xAC080000, with a correct checksum.
  - Expect o_we at addresses 0 and 1 with those exact words.
  - Expect o_word_cnt=2, then o_done=1 and o_core_rst_n=1.
- Same image with the checksum byte XORed with 0x01 -> o_err=1, o_core_rst_n=0, o_done=0.
- N=0x00002001 with ADDR_W=13 -> ERR after the 4th length byte, no o_we pulse, o_byte_ready=0.
- Random i_byte_valid gaps (50% duty) over N=16 words -> identical writes and final state to the gap-free run.
- Assert i_rst during the 3rd word's 2nd byte.
  - Expect all outputs at reset values asynchronously.
  - Then i_start and a full N=1 load -> writes address 0 and ends in DONE.
- i_start pulsed during DATA -> ignored. Then i_start in DONE -> o_core_rst_n falls and a new load begins at address 0.
